buffer_ctrl: RTL and testbench
==============================

// Module: buffer_ctrl
// PURPOSE
//   Occupancy/pointer controller for the circular multi-word buffer (PAR_WRITE-wide write, PAR_READ-wide read window).
//   Producer pushes PAR_WRITE words per handshake. Consumer sees a PAR_READ-word window and pops STRIDE words per handshake.
//   Sits between the input streamer and the PE array; drives the buffer's wen/waddr/raddr directly.
// PARAMETERS
//   PAR_WRITE  2   words written per push (must match buffer PAR_WRITE)
//   PAR_READ   3   words in read window (must match buffer PAR_READ)
//   STRIDE     1   words released per pop; legal 1..PAR_READ
//   DEPTH      8   buffer depth in words; legal DEPTH >= PAR_WRITE+PAR_READ
//   INDEX      3   address width, = clog2(DEPTH)
// PORTS
//   clk        in   1        clock, rising edge
//   rst_n      in   1        asynchronous reset, active low
//   wr_valid   in   1        producer has PAR_WRITE words on buffer din
//   wr_ready   out  1        room for PAR_WRITE words
//   rd_valid   out  1        PAR_READ-word window valid on buffer dout
//   rd_ready   in   1        consumer takes window, releases STRIDE words
//   buf_wen    out  1        buffer write enable
//   buf_waddr  out  INDEX    buffer write base address
//   buf_raddr  out  INDEX    buffer read base address
//   count      out  INDEX+1  words currently held, 0..DEPTH
//   full       out  1        count == DEPTH
//   empty      out  1        count == 0
// BEHAVIOUR
//   Reset (async, rst_n=0): wptr=0, rptr=0, count=0; so wr_ready=1, rd_valid=0, buf_wen=0, full=0, empty=1.
//   push = wr_valid & wr_ready; pop = rd_valid & rd_ready.
//   wr_ready = (DEPTH-count) >= PAR_WRITE. Uses registered count only; a same-cycle pop does not raise wr_ready.
//   rd_valid = count >= PAR_READ. Uses registered count only.
//   buf_wen = push (combinational); buf_waddr = wptr; buf_raddr = rptr (combinational).
//     Buffer read is combinational, so the window is valid in the same cycle as rd_valid.
//   On clk edge:
//     push -> wptr <= wrap(wptr+PAR_WRITE).
//     pop  -> rptr <= wrap(rptr+STRIDE).
//     count <= count + (push?PAR_WRITE:0) - (pop?STRIDE:0). Simultaneous push+pop is a single net update.
//   wrap(x) = (x>=DEPTH) ? x-DEPTH : x. Computed at INDEX+1 bits; DEPTH need not be a power of 2.
//   count never exceeds DEPTH and never underflows. Guaranteed by the ready/valid gating.
//   wr_valid while !wr_ready: no write, no pointer move; producer holds data.
//   rd_ready while !rd_valid: ignored.
//   Reset asserted mid-transfer: state clears immediately. The in-flight push is not written: buf_wen is gated by rst_n.
// CONFIGURATION
//   BUFFER_CTRL_FLUSH_EN defined:
//     Adds port flush (in, 1). flush=1 at an edge sets wptr=rptr=0, count=0.
//     flush has priority over a same-cycle push and pop; buf_wen is forced 0 while flush=1.
//   Not defined: no flush port. Contents are discarded only via rst_n.
// STRUCTURE
//   Shared package buffer_pkg:
//     clog2 function
//     default PAR_WRITE/PAR_READ/DEPTH/STRIDE constants shared with the buffer instance
//     count-width localparam CNT_W = INDEX+1
//   Sub-module ring_ptr_adv (ptr, inc, en -> next ptr with DEPTH wrap), instantiated twice: write and read pointer.
//   Flags and handshakes stay in buffer_ctrl.
// TESTING (defaults DEPTH=8, PAR_WRITE=2, PAR_READ=3, STRIDE=1)
//   Reset release: wr_ready=1, rd_valid=0, empty=1, buf_waddr=0, buf_raddr=0, count=0.
//   4 back-to-back pushes, rd_ready=0:
//     buf_waddr 0,2,4,6; count 2,4,6,8; full=1, wr_ready=0 after the 4th.
//     A 5th wr_valid produces no buf_wen.
//   From count=8, 6 pops:
//     buf_raddr 0..5; rd_valid drops when count=2.
//     Then a push writes at waddr=0 (wrap) and count=4.
//   count=6, push+pop same cycle -> count=7, wptr+2 and rptr+1 both applied, wr_ready=0 next cycle.
//   Wrap of read window: rptr=7, count=3 -> buf_raddr=7, rd_valid=1; after pop buf_raddr=0.
//   rst_n low mid-push with count=5: outputs return to reset values asynchronously, no buf_wen that cycle.
//     With BUFFER_CTRL_FLUSH_EN, the same check is repeated using flush.

Source files
------------

// File: rtl/buffer_pkg.sv
// Shared constants and helpers for the circular multi-word buffer and its controller.
package buffer_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Defaults shared with the buffer instance so both sides agree on geometry.
  localparam int BUF_PAR_WRITE = 2;
  localparam int BUF_PAR_READ  = 3;
  localparam int BUF_STRIDE    = 1;
  localparam int BUF_DEPTH     = 8;
  localparam int BUF_INDEX     = clog2(BUF_DEPTH);
  localparam int CNT_W         = BUF_INDEX + 1;

endpackage

// File: rtl/buffer_ctrl_if.sv
// Producer/consumer handshake, buffer address/enable and occupancy status of buffer_ctrl.
interface buffer_ctrl_if #(
  parameter int INDEX = 3
);
  logic             wr_valid;
  logic             wr_ready;
  logic             rd_valid;
  logic             rd_ready;
  logic             buf_wen;
  logic [INDEX-1:0] buf_waddr;
  logic [INDEX-1:0] buf_raddr;
  logic [INDEX:0]   count;
  logic             full;
  logic             empty;

  modport slave (
    input  wr_valid, rd_ready,
    output wr_ready, rd_valid, buf_wen, buf_waddr, buf_raddr, count, full, empty
  );

  modport master (
    output wr_valid, rd_ready,
    input  wr_ready, rd_valid, buf_wen, buf_waddr, buf_raddr, count, full, empty
  );
endinterface

// File: rtl/ring_ptr_adv.sv
// Next-pointer logic for a ring of DEPTH words; DEPTH need not be a power of two.
module ring_ptr_adv #(
  parameter int DEPTH = 8,
  parameter int INDEX = 3
) (
  input  logic [INDEX-1:0] ptr,
  input  logic [INDEX:0]   inc,
  input  logic             en,
  output logic [INDEX-1:0] nxt
);
  localparam logic [INDEX:0] DEPTH_C = (INDEX+1)'(DEPTH);

  logic [INDEX:0] sum;
  logic [INDEX:0] wrapped;

  // ptr < DEPTH and inc <= DEPTH, so one conditional subtract is a full wrap.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    sum     = {1'b0, ptr} + inc;
    wrapped = (sum >= DEPTH_C) ? sum - DEPTH_C : sum;
    nxt     = en ? wrapped[INDEX-1:0] : ptr;
  end
endmodule

// File: rtl/buffer_ctrl.sv
// Occupancy/pointer controller for the circular multi-word buffer.
// Optional synchronous flush port enabled by BUFFER_CTRL_FLUSH_EN.
module buffer_ctrl
  import buffer_pkg::*;
#(
  parameter int PAR_WRITE = BUF_PAR_WRITE,
  parameter int PAR_READ  = BUF_PAR_READ,
  parameter int STRIDE    = BUF_STRIDE,
  parameter int DEPTH     = BUF_DEPTH,
  parameter int INDEX     = clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
`ifdef BUFFER_CTRL_FLUSH_EN
  input  logic         flush,
`endif
  buffer_ctrl_if.slave bus
);
  localparam int CW = INDEX + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] PW_C    = CW'(PAR_WRITE);
  localparam logic [CW-1:0] PR_C    = CW'(PAR_READ);
  localparam logic [CW-1:0] ST_C    = CW'(STRIDE);

  logic [INDEX-1:0] wptr, rptr;
  logic [INDEX-1:0] wptr_nxt, rptr_nxt;
  logic [CW-1:0]    count_q;
  logic             push, pop, flush_i;

`ifdef BUFFER_CTRL_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  // Handshakes look only at registered occupancy, never at a same-cycle pop.
  assign bus.wr_ready = (DEPTH_C - count_q) >= PW_C;
  assign bus.rd_valid = count_q >= PR_C;

  assign push = bus.wr_valid & bus.wr_ready & ~flush_i;
  assign pop  = bus.rd_valid & bus.rd_ready & ~flush_i;

  // Gating by rst_n keeps a write that is in flight when reset hits from landing.
  assign bus.buf_wen   = push & rst_n;
  assign bus.buf_waddr = wptr;
  assign bus.buf_raddr = rptr;
  assign bus.count     = count_q;
  assign bus.full      = (count_q == DEPTH_C);
  assign bus.empty     = (count_q == '0);

  ring_ptr_adv #(.DEPTH(DEPTH), .INDEX(INDEX)) u_wr_adv (
    .ptr (wptr),
    .inc (PW_C),
    .en  (push),
    .nxt (wptr_nxt)
  );

  ring_ptr_adv #(.DEPTH(DEPTH), .INDEX(INDEX)) u_rd_adv (
    .ptr (rptr),
    .inc (ST_C),
    .en  (pop),
    .nxt (rptr_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wptr    <= '0;
      rptr    <= '0;
      count_q <= '0;
    end else begin
      wptr    <= wptr_nxt;
      rptr    <= rptr_nxt;
      count_q <= count_q + (push ? PW_C : '0) - (pop ? ST_C : '0);
    end
  end
endmodule

// File: tb/tb_buffer_ctrl.sv
// Self-checking bench for buffer_ctrl: directed vector table, corner sequences, random vs. model.
module tb_buffer_ctrl;
  localparam int DEPTH = 8;
  localparam int PW    = 2;
  localparam int PR    = 3;
  localparam int ST    = 1;
  localparam int INDEX = 3;

  logic clk;
  logic rst_n;
`ifdef BUFFER_CTRL_FLUSH_EN
  logic flush;
`endif

  buffer_ctrl_if #(.INDEX(INDEX)) bus ();

  buffer_ctrl #(
    .PAR_WRITE(PW), .PAR_READ(PR), .STRIDE(ST), .DEPTH(DEPTH), .INDEX(INDEX)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef BUFFER_CTRL_FLUSH_EN
    .flush (flush),
`endif
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic wv;
    logic rr;
    logic wen;
    int   waddr;
    int   raddr;
    int   count;
    logic wrr;
    logic rdv;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic wen, input int waddr, input int raddr,
                             input int count, input logic wrr, input logic rdv);
    check({tag, ".buf_wen"},   32'(bus.buf_wen),   32'(wen));
    check({tag, ".buf_waddr"}, 32'(bus.buf_waddr), 32'(waddr));
    check({tag, ".buf_raddr"}, 32'(bus.buf_raddr), 32'(raddr));
    check({tag, ".count"},     32'(bus.count),     32'(count));
    check({tag, ".wr_ready"},  32'(bus.wr_ready),  32'(wrr));
    check({tag, ".rd_valid"},  32'(bus.rd_valid),  32'(rdv));
    check({tag, ".full"},      32'(bus.full),      32'(count == DEPTH));
    check({tag, ".empty"},     32'(bus.empty),     32'(count == 0));
  endtask

  // Drive at the falling edge, then sample 1 time unit later, far from the rising edge.
  task automatic drive(input logic wv, input logic rr);
    @(negedge clk);
    bus.wr_valid = wv;
    bus.rd_ready = rr;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Model state: total words ever pushed/popped since reset; pointers follow by modulo.
  int pushed_words;
  int popped_words;

  initial begin
    rst_n        = 1'b0;
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b0;
`ifdef BUFFER_CTRL_FLUSH_EN
    flush = 1'b0;
`endif

    //            wv    rr    wen   wa ra cnt wrr   rdv
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 0, 0, 0, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 2, 0, 2, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 4, 0, 4, 1'b1, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 6, 0, 6, 1'b1, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 0, 0, 8, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 0, 0, 8, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 0, 1, 7, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 0, 2, 6, 1'b1, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 0, 3, 5, 1'b1, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 0, 4, 4, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 0, 5, 3, 1'b1, 1'b1};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 0, 6, 2, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 2, 6, 4, 1'b1, 1'b1};

    #1;
    check_state("reset_async", 1'b0, 0, 0, 0, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_state("reset_release", 1'b0, 0, 0, 0, 1'b1, 1'b0);

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].wv, vecs[i].rr);
      check_state($sformatf("vec%0d", i), vecs[i].wen, vecs[i].waddr, vecs[i].raddr,
                  vecs[i].count, vecs[i].wrr, vecs[i].rdv);
    end

    // Bring count to 6, then push and pop in the same cycle.
    drive(1'b1, 1'b0);
    check_state("pre_pp", 1'b1, 2, 6, 4, 1'b1, 1'b1);
    drive(1'b1, 1'b1);
    check_state("push_pop", 1'b1, 4, 6, 6, 1'b1, 1'b1);
    drive(1'b0, 1'b0);
    check_state("after_pp", 1'b0, 6, 7, 7, 1'b0, 1'b1);
    // Read window starting at the last word, then wrap to 0.
    drive(1'b0, 1'b1);
    check_state("rwrap_pop", 1'b0, 6, 7, 7, 1'b0, 1'b1);
    drive(1'b0, 1'b0);
    check_state("rwrap_done", 1'b0, 6, 0, 6, 1'b1, 1'b1);

    // Randomized traffic against the totals-based model.
    do_reset();
    pushed_words = 0;
    popped_words = 0;
    for (int i = 0; i < 1500; i++) begin
      logic wv, rr, exp_wrr, exp_rdv;
      int   occ;
      if ((i % 300) < 150) begin
        wv = ($urandom_range(0, 3) != 0);
        rr = ($urandom_range(0, 3) == 0);
      end else begin
        wv = ($urandom_range(0, 3) == 0);
        rr = ($urandom_range(0, 3) != 0);
      end
      drive(wv, rr);
      occ     = pushed_words - popped_words;
      exp_wrr = (DEPTH - occ) >= PW;
      exp_rdv = occ >= PR;
      check_state($sformatf("rnd%0d", i), wv & exp_wrr, pushed_words % DEPTH,
                  popped_words % DEPTH, occ, exp_wrr, exp_rdv);
      if (wv && exp_wrr) pushed_words += PW;
      if (rr && exp_rdv) popped_words += ST;
    end

    // Reset asserted mid-push with count=5.
    do_reset();
    repeat (3) drive(1'b1, 1'b0);
    drive(1'b0, 1'b1);
    drive(1'b1, 1'b0);
    check_state("mid_pre", 1'b1, 6, 1, 5, 1'b1, 1'b1);
    rst_n = 1'b0;
    #1;
    check_state("mid_rst", 1'b0, 0, 0, 0, 1'b1, 1'b0);
    @(negedge clk);
    rst_n        = 1'b1;
    bus.wr_valid = 1'b0;
    #1;
    check_state("mid_rst_rel", 1'b0, 0, 0, 0, 1'b1, 1'b0);

`ifdef BUFFER_CTRL_FLUSH_EN
    repeat (3) drive(1'b1, 1'b0);
    drive(1'b0, 1'b1);
    drive(1'b1, 1'b0);
    check_state("fl_pre", 1'b1, 6, 1, 5, 1'b1, 1'b1);
    flush = 1'b1;
    bus.rd_ready = 1'b1;
    #1;
    check("fl_wen_forced", 32'(bus.buf_wen), 32'd0);
    @(negedge clk);
    flush        = 1'b0;
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b0;
    #1;
    check_state("fl_done", 1'b0, 0, 0, 0, 1'b1, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
